// File: rtl/song_reader_if.sv
// song_reader_if
// Bundles the two buses song_reader drives: the synchronous note ROM
// (address out, data back one cycle later) and the load handshake with
// note_player (note/duration/load pulse out, note_done back).
//
// Modports:
//   master : song_reader side  (drives rom_addr, note/duration, load pulse)
//   slave  : ROM + note_player side (drives rom_data, note_done)
interface song_reader_if #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter int SONG_W = 2,
  parameter int ADDR_W = 5
);
  logic [SONG_W+ADDR_W-1:0] rom_addr;
  logic [NOTE_W+DUR_W-1:0]  rom_data;
  logic [NOTE_W-1:0]        note_to_load;
  logic [DUR_W-1:0]         duration_to_load;
  logic                     load_new_note;
  logic                     note_done;

  modport master (
    output rom_addr,
    output note_to_load,
    output duration_to_load,
    output load_new_note,
    input  rom_data,
    input  note_done
  );

  modport slave (
    input  rom_addr,
    input  note_to_load,
    input  duration_to_load,
    input  load_new_note,
    output rom_data,
    output note_done
  );
endinterface

// File: rtl/song_reader.sv
// song_reader
// Walks one song of a synchronous note ROM and hands each {note, duration}
// entry to note_player with a one-cycle load pulse, then waits for
// note_done before fetching the next entry. A duration of 0 marks the end
// of a song; a song may also end by finishing its last entry.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset      asynchronous, active-low
//   play       play enable (starts a song from IDLE)
//   song       song select, sampled only on new_song
//   new_song   1-cycle pulse, restart at entry 0 of the selected song
//   song_done  end-of-song indication (level; 1-cycle pulse in loop builds)
//   bus        song_reader_if.master: rom_addr/rom_data, note_to_load,
//              duration_to_load, load_new_note, note_done
//
// Build option: define SONG_READER_LOOP_EN to make every song repeat
// forever; song_done then pulses for one cycle at each wrap.
//
// State table:
//   state   | meaning
//   IDLE    | waiting for play; rom_addr already holds {song_reg, entry}
//   FETCH   | ROM samples rom_addr on this edge
//   WAIT    | rom_data valid; end marker ends the song, else latch entry
//   LOAD    | schedules the load pulse for the next cycle
//   PLAYING | note_player busy; note_done advances or ends the song
//   DONE    | song finished, outputs frozen until new_song or reset
module song_reader #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter int SONG_W = 2,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic [SONG_W-1:0] song,
  input  logic              new_song,
  output logic              song_done,
  song_reader_if.master     bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_PLAYING,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ENTRY = '1;

`ifdef SONG_READER_LOOP_EN
  localparam state_t END_STATE = S_FETCH;
`else
  localparam state_t END_STATE = S_DONE;
`endif

  state_t state, state_nx;

  logic [SONG_W-1:0] song_reg, song_nx;
  logic [ADDR_W-1:0] entry, entry_nx;
  logic [NOTE_W-1:0] note_q, note_nx;
  logic [DUR_W-1:0]  dur_q, dur_nx;
  logic              load_q, load_nx;
  logic              done_q, done_nx;

  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;
  logic              end_marker;
  logic              last_finished;
  logic              song_end;

  assign rom_note      = bus.rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur       = bus.rom_data[DUR_W-1:0];
  assign end_marker    = (rom_dur == '0);
  assign last_finished = bus.note_done && (entry == LAST_ENTRY);

  // Both ways a song can end; new_song overrides either.
  assign song_end = !new_song &&
                    (((state == S_WAIT) && end_marker) ||
                     ((state == S_PLAYING) && last_finished));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    if (new_song) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (play) state_nx = S_FETCH;
        S_FETCH:   state_nx = S_WAIT;
        S_WAIT:    state_nx = end_marker ? END_STATE : S_LOAD;
        S_LOAD:    state_nx = S_PLAYING;
        S_PLAYING: begin
          if (bus.note_done) begin
            state_nx = (entry == LAST_ENTRY) ? END_STATE : S_FETCH;
          end
        end
        S_DONE:    state_nx = S_DONE;
        default:   state_nx = S_IDLE;
      endcase
    end
  end

  // Output / datapath next values. The load pulse is registered, so it is
  // seen in the cycle after LOAD, with note/duration already stable.
  always_comb begin
    song_nx  = song_reg;
    entry_nx = entry;
    note_nx  = note_q;
    dur_nx   = dur_q;
    load_nx  = 1'b0;
`ifdef SONG_READER_LOOP_EN
    done_nx  = 1'b0;
`else
    done_nx  = done_q;
`endif

    if (new_song) begin
      song_nx  = song;
      entry_nx = '0;
      done_nx  = 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (!end_marker) begin
            note_nx = rom_note;
            dur_nx  = rom_dur;
          end
        end
        S_LOAD:    load_nx = 1'b1;
        S_PLAYING: begin
          // Saturate at the last entry so rom_addr never reaches the next song.
          if (bus.note_done && !last_finished) begin
            entry_nx = entry + ADDR_W'(1);
          end
        end
        default: ;
      endcase

      if (song_end) begin
        done_nx = 1'b1;
`ifdef SONG_READER_LOOP_EN
        entry_nx = '0;
`endif
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      song_reg <= '0;
      entry    <= '0;
      note_q   <= '0;
      dur_q    <= '0;
      load_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      song_reg <= song_nx;
      entry    <= entry_nx;
      note_q   <= note_nx;
      dur_q    <= dur_nx;
      load_q   <= load_nx;
      done_q   <= done_nx;
    end
  end

  assign bus.rom_addr         = {song_reg, entry};
  assign bus.note_to_load     = note_q;
  assign bus.duration_to_load = dur_q;
  assign bus.load_new_note    = load_q;
  assign song_done            = done_q;

endmodule

// File: tb/tb_song_reader.sv
module tb_song_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       play = 1'b0;
  logic [1:0] song = 2'd0;
  logic       new_song = 1'b0;
  logic       song_done;

  song_reader_if #(.NOTE_W(6), .DUR_W(6), .SONG_W(2), .ADDR_W(5)) bus_if ();

  song_reader dut (
    .clk       (clk),
    .reset     (reset),
    .play      (play),
    .song      (song),
    .new_song  (new_song),
    .song_done (song_done),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  // Synchronous ROM model: data valid one cycle after the address.
  logic [11:0] rom_mem [0:127];
  always @(posedge clk) bus_if.rom_data <= rom_mem[bus_if.rom_addr];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int load_cnt = 0;
  int load_cyc = 0;
  int nd_cyc = 0;
  bit prev_load = 1'b0;
  bit watch_s1 = 1'b0;
  bit saw64 = 1'b0;
  logic [11:0] exp_q [$];

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_entry(input int s, input int e);
    exp_q.push_back(rom_mem[s*32 + e]);
  endtask

  // Scoreboard side: every observed load pops one expected entry.
  always @(negedge clk) begin
    logic [11:0] e;
    if (reset) begin
      if (bus_if.load_new_note) begin
        load_cnt++;
        load_cyc = cyc;
        chk("load_gap", {31'd0, prev_load}, 0);
        chk("load_queued", {31'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("load_note", {26'd0, bus_if.note_to_load}, {26'd0, e[11:6]});
          chk("load_dur", {26'd0, bus_if.duration_to_load}, {26'd0, e[5:0]});
        end
      end
      prev_load = bus_if.load_new_note;
      if (watch_s1 && bus_if.rom_addr == 7'd64) saw64 = 1'b1;
    end else begin
      prev_load = 1'b0;
    end
  end

  task automatic wait_load(input string tag);
    int n0;
    bit got;
    n0 = load_cnt;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick(1);
      if (load_cnt != n0) got = 1'b1;
    end
    chk({tag, "_arrive"}, {31'd0, got}, 1);
  endtask

  task automatic send_note_done();
    bus_if.note_done = 1'b1;
    tick(1);
    nd_cyc = cyc;
    bus_if.note_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ref_cyc;
    int n;
    for (int i = 0; i < 128; i++) rom_mem[i] = 12'd0;
    rom_mem[0] = {6'd38, 6'd10};
    rom_mem[1] = {6'd48, 6'd7};
    rom_mem[2] = {6'd58, 6'd4};
    rom_mem[3] = {6'd0, 6'd0};
    for (int e = 0; e < 32; e++) rom_mem[32 + e] = {6'(e + 1), 6'((e % 5) + 1)};
    rom_mem[64] = {6'd20, 6'd3};
    rom_mem[65] = {6'd0, 6'd0};
    bus_if.note_done = 1'b0;

    // Reset state
    tick(3);
    chk("rst_rom_addr", {25'd0, bus_if.rom_addr}, 0);
    chk("rst_note", {26'd0, bus_if.note_to_load}, 0);
    chk("rst_dur", {26'd0, bus_if.duration_to_load}, 0);
    chk("rst_load", {31'd0, bus_if.load_new_note}, 0);
    chk("rst_song_done", {31'd0, song_done}, 0);
    reset = 1'b1;
    tick(2);

    // Song 0 end to end
    push_entry(0, 0);
    play = 1'b1;
    tick(1);
    ref_cyc = cyc;
    wait_load("s0_e0");
    chk("s0_first_latency", load_cyc - ref_cyc, 3);
    for (int k = 1; k <= 3; k++) begin
      tick(19);
      if (k < 3) push_entry(0, k);
      send_note_done();
      if (k < 3) begin
        wait_load("s0_next");
        chk("s0_nd_latency", load_cyc - nd_cyc, 3);
      end
    end
    tick(6);
    chk("s0_song_done", {31'd0, song_done}, 1);
    chk("s0_end_addr", {25'd0, bus_if.rom_addr}, 3);
    n = load_cnt;
    tick(20);
    chk("s0_no_4th_load", load_cnt, n);

    // Restart song 0, then switch to song 2 mid-note
    push_entry(0, 0);
    new_song = 1'b1;
    tick(1);
    new_song = 1'b0;
    chk("restart_song_done", {31'd0, song_done}, 0);
    wait_load("s0r_e0");
    tick(10);
    push_entry(0, 1);
    send_note_done();
    wait_load("s0r_e1");
    tick(5);
    song = 2'd2;
    push_entry(2, 0);
    new_song = 1'b1;
    tick(1);
    new_song = 1'b0;
    chk("sw_song_done", {31'd0, song_done}, 0);
    chk("sw_rom_addr", {25'd0, bus_if.rom_addr}, 64);
    wait_load("s2_e0");
    tick(5);
    send_note_done();
    tick(6);
    chk("s2_song_done", {31'd0, song_done}, 1);
    chk("s2_end_addr", {25'd0, bus_if.rom_addr}, 65);

    // new_song and note_done in the same cycle
    song = 2'd0;
    push_entry(0, 0);
    new_song = 1'b1;
    tick(1);
    new_song = 1'b0;
    wait_load("coll_pre");
    tick(5);
    push_entry(0, 0);
    new_song = 1'b1;
    bus_if.note_done = 1'b1;
    tick(1);
    new_song = 1'b0;
    bus_if.note_done = 1'b0;
    chk("coll_rom_addr", {25'd0, bus_if.rom_addr}, 0);
    wait_load("coll_restart");

    // Reset asserted while in LOAD
    tick(3);
    push_entry(0, 1);
    send_note_done();
    tick(2);
    reset = 1'b0;
    #1;
    chk("midload_note", {26'd0, bus_if.note_to_load}, 0);
    chk("midload_dur", {26'd0, bus_if.duration_to_load}, 0);
    chk("midload_load", {31'd0, bus_if.load_new_note}, 0);
    chk("midload_rom_addr", {25'd0, bus_if.rom_addr}, 0);
    chk("midload_song_done", {31'd0, song_done}, 0);
    exp_q.delete();
    n = load_cnt;
    tick(2);
    chk("midload_no_load", load_cnt, n);
    reset = 1'b1;
    chk("rel_rom_addr", {25'd0, bus_if.rom_addr}, 0);
    push_entry(0, 0);
    tick(1);
    ref_cyc = cyc;
    wait_load("rel_e0");
    chk("rel_latency", load_cyc - ref_cyc, 3);

    // Song 1: all 32 entries populated
    song = 2'd1;
    push_entry(1, 0);
    new_song = 1'b1;
    tick(1);
    new_song = 1'b0;
    watch_s1 = 1'b1;
    wait_load("s1_e0");
    for (int e = 1; e < 32; e++) begin
      tick(3);
      push_entry(1, e);
      send_note_done();
      wait_load("s1_next");
      chk("s1_latency", load_cyc - nd_cyc, 3);
    end
    tick(3);
    send_note_done();
    tick(6);
    chk("s1_song_done", {31'd0, song_done}, 1);
    chk("s1_end_addr", {25'd0, bus_if.rom_addr}, 63);
    n = load_cnt;
    tick(10);
    chk("s1_no_33rd_load", load_cnt, n);
    chk("s1_saw_addr64", {31'd0, saw64}, 0);
    watch_s1 = 1'b0;
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
